// File: rtl/ray_dispatcher.sv
// ray_dispatcher
//   Frame-level initiator for the folded ray generator. A start pulse makes
//   it walk every pixel in raster order. For each pixel it issues one
//   (hcount, vcount, cam_forward) request to the generator and captures the
//   returned ray direction. Each captured ray is tagged with its pixel
//   coordinates and pushed into a show-ahead FIFO that feeds the ray marcher.
//   frame_done_out pulses once the last tagged ray has left the FIFO.
//
// Ports
//   clk_in, rst_n_in          clock; synchronous active-low reset
//   start_in, cam_forward_in  frame start (honoured only when idle) and camera
//                             forward vector, latched when the start is taken
//   gen_valid_out/gen_ready_in, gen_hcount_out/gen_vcount_out,
//   gen_cam_forward_out       request side of the generator
//   gen_valid_in, gen_ray_in  generator result; only looked at while waiting
//   ray_valid_out/ray_ready_in, ray_hcount_out/ray_vcount_out,
//   ray_direction_out         tagged-ray stream to the marcher (FIFO head)
//   busy_out, frame_done_out  frame in progress / one-cycle completion pulse

`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_dispatcher #(
  parameter int unsigned DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int unsigned DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int unsigned H_BITS         = `H_BITS,
  parameter int unsigned V_BITS         = `V_BITS,
  parameter int unsigned VEC_BITS       = 48,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_in,
  input  logic [VEC_BITS-1:0] cam_forward_in,
  output logic                gen_valid_out,
  input  logic                gen_ready_in,
  output logic [H_BITS-1:0]   gen_hcount_out,
  output logic [V_BITS-1:0]   gen_vcount_out,
  output logic [VEC_BITS-1:0] gen_cam_forward_out,
  input  logic                gen_valid_in,
  input  logic [VEC_BITS-1:0] gen_ray_in,
  output logic                ray_valid_out,
  input  logic                ray_ready_in,
  output logic [H_BITS-1:0]   ray_hcount_out,
  output logic [V_BITS-1:0]   ray_vcount_out,
  output logic [VEC_BITS-1:0] ray_direction_out,
  output logic                busy_out,
  output logic                frame_done_out
);

  localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);

  localparam logic [H_BITS-1:0]   H_LAST    = H_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [V_BITS-1:0]   V_LAST    = V_BITS'(DISPLAY_HEIGHT - 1);
  localparam logic [H_BITS-1:0]   H_ONE     = H_BITS'(1);
  localparam logic [V_BITS-1:0]   V_ONE     = V_BITS'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE   = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS:0]   CNT_DEPTH = (PTR_BITS + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [H_BITS-1:0]   h;
    logic [V_BITS-1:0]   v;
    logic [VEC_BITS-1:0] ray;
  } entry_t;

  state_t              state;
  logic [H_BITS-1:0]   h;
  logic [V_BITS-1:0]   v;
  logic [VEC_BITS-1:0] cam_q;
  logic                frame_done_q;

  entry_t              mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;

  logic push;
  logic pop;
  logic last_pixel;

  // Requests are held back while the FIFO is full. Because only one request
  // is ever outstanding, every captured result is guaranteed a free slot.
  assign gen_valid_out = (state == ISSUE) && (count < CNT_DEPTH);
  assign push          = (state == WAIT) && gen_valid_in;
  assign pop           = ray_valid_out && ray_ready_in;
  assign last_pixel    = (h == H_LAST) && (v == V_LAST);

  assign gen_hcount_out      = h;
  assign gen_vcount_out      = v;
  assign gen_cam_forward_out = cam_q;

  assign ray_valid_out     = (count != '0);
  assign ray_hcount_out    = mem[rd_ptr].h;
  assign ray_vcount_out    = mem[rd_ptr].v;
  assign ray_direction_out = mem[rd_ptr].ray;

  assign busy_out       = (state != IDLE);
  assign frame_done_out = frame_done_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      h            <= '0;
      v            <= '0;
      cam_q        <= '0;
      frame_done_q <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (start_in) begin
            cam_q <= cam_forward_in;
            h     <= '0;
            v     <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (gen_valid_out && gen_ready_in) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (gen_valid_in) begin
            if (last_pixel) begin
              state <= DRAIN;
            end else begin
              if (h == H_LAST) begin
                h <= '0;
                v <= v + V_ONE;
              end else begin
                h <= h + H_ONE;
              end
              state <= ISSUE;
            end
          end
        end
        DRAIN: begin
          if (count == '0) begin
            frame_done_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        mem[wr_ptr] <= '{h: h, v: v, ray: gen_ray_in};
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
`timescale 1ns/1ps
module tb_ray_dispatcher;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int HB    = 3;
  localparam int VB    = 2;
  localparam int VW    = 48;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_in;
  logic [VW-1:0] cam_forward_in;
  logic          gen_valid_out;
  logic          gen_ready_in;
  logic [HB-1:0] gen_hcount_out;
  logic [VB-1:0] gen_vcount_out;
  logic [VW-1:0] gen_cam_forward_out;
  logic          gen_valid_in;
  logic [VW-1:0] gen_ray_in;
  logic          ray_valid_out;
  logic          ray_ready_in;
  logic [HB-1:0] ray_hcount_out;
  logic [VB-1:0] ray_vcount_out;
  logic [VW-1:0] ray_direction_out;
  logic          busy_out;
  logic          frame_done_out;

  ray_dispatcher #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .H_BITS        (HB),
    .V_BITS        (VB),
    .VEC_BITS      (VW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .start_in           (start_in),
    .cam_forward_in     (cam_forward_in),
    .gen_valid_out      (gen_valid_out),
    .gen_ready_in       (gen_ready_in),
    .gen_hcount_out     (gen_hcount_out),
    .gen_vcount_out     (gen_vcount_out),
    .gen_cam_forward_out(gen_cam_forward_out),
    .gen_valid_in       (gen_valid_in),
    .gen_ray_in         (gen_ray_in),
    .ray_valid_out      (ray_valid_out),
    .ray_ready_in       (ray_ready_in),
    .ray_hcount_out     (ray_hcount_out),
    .ray_vcount_out     (ray_vcount_out),
    .ray_direction_out  (ray_direction_out),
    .busy_out           (busy_out),
    .frame_done_out     (frame_done_out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            h;
    int            v;
    logic [VW-1:0] ray;
  } exp_t;
  exp_t sb[$];

  // environment knobs (written by the stimulus process)
  int rdy_mode = 0;   // 0: downstream always ready, 1: never, 2: random
  bit gen_hold = 0;   // force generator ready low
  bit gen_rand = 0;   // random generator ready
  bit stale    = 0;   // generator holds result valid until next accept
  int lat      = 3;

  // environment observations (written by the tick process)
  int accepts = 0;
  int pops    = 0;
  int dones   = 0;
  bit pend    = 0;

  function automatic logic [VW-1:0] ray_of(int h, int v, logic [VW-1:0] cam);
    return cam ^ {16'(h * 3 + 1), 16'(v * 5 + 2), 16'(h * 7 + v * 11 + 3)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mock generator, downstream ready driver and scoreboard monitor.
  // Everything happens on the falling edge, half a cycle from DUT updates.
  initial begin
    int            cnt;
    int            req_h;
    int            req_v;
    logic [VW-1:0] req_cam;
    bit            prev_req;
    int            prev_h;
    int            prev_v;
    logic [VW-1:0] prev_cam;
    bit            prev_done;
    exp_t          e;
    cnt = 0; req_h = 0; req_v = 0; req_cam = '0;
    prev_req = 0; prev_h = 0; prev_v = 0; prev_cam = '0; prev_done = 0;
    gen_ready_in = 1'b1;
    gen_valid_in = 1'b0;
    gen_ray_in   = '0;
    ray_ready_in = 1'b1;
    forever begin
      @(negedge clk);
      if (!stale && gen_valid_in) gen_valid_in = 1'b0;
      if (prev_req) begin
        accepts++;
        pend    = 1;
        cnt     = lat;
        req_h   = prev_h;
        req_v   = prev_v;
        req_cam = prev_cam;
        if (stale) gen_valid_in = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          pend         = 0;
          gen_valid_in = 1'b1;
          gen_ray_in   = ray_of(req_h, req_v, req_cam);
        end
      end
      if (!rst_n) begin
        pend         = 0;
        cnt          = 0;
        gen_valid_in = 1'b0;
      end
      gen_ready_in = gen_hold ? 1'b0 : (gen_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      ray_ready_in = (rdy_mode == 0) ? 1'b1 :
                     (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 1) == 1);

      if (frame_done_out) begin
        dones++;
        check("done_single_cycle", 64'(prev_done), 64'd0);
      end
      if (ray_valid_out && ray_ready_in) begin
        pops++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ray: got (%0d,%0d) expected no output", ray_hcount_out, ray_vcount_out);
        end else begin
          e = sb.pop_front();
          check("ray_h", 64'(ray_hcount_out), 64'(e.h));
          check("ray_v", 64'(ray_vcount_out), 64'(e.v));
          check("ray_dir", 64'(ray_direction_out), 64'(e.ray));
        end
      end
      prev_req  = gen_valid_out && gen_ready_in && rst_n;
      prev_h    = int'(gen_hcount_out);
      prev_v    = int'(gen_vcount_out);
      prev_cam  = gen_cam_forward_out;
      prev_done = frame_done_out;
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_gen_valid"}, 64'(gen_valid_out), 64'd0);
    check({tag, "_ray_valid"}, 64'(ray_valid_out), 64'd0);
    check({tag, "_busy"}, 64'(busy_out), 64'd0);
    check({tag, "_done"}, 64'(frame_done_out), 64'd0);
    check({tag, "_hcount"}, 64'(gen_hcount_out), 64'd0);
    check({tag, "_vcount"}, 64'(gen_vcount_out), 64'd0);
    check({tag, "_cam"}, 64'(gen_cam_forward_out), 64'd0);
    check({tag, "_ray_h"}, 64'(ray_hcount_out), 64'd0);
    check({tag, "_ray_v"}, 64'(ray_vcount_out), 64'd0);
    check({tag, "_ray_dir"}, 64'(ray_direction_out), 64'd0);
  endtask

  task automatic start_frame(logic [VW-1:0] cam);
    exp_t e;
    accepts = 0;
    for (int v = 0; v < H; v++) begin
      for (int h = 0; h < W; h++) begin
        e.h   = h;
        e.v   = v;
        e.ray = ray_of(h, v, cam);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    start_in       = 1'b1;
    cam_forward_in = cam;
    @(negedge clk);
    start_in       = 1'b0;
    cam_forward_in = ~cam;
    check("start_gen_valid", 64'(gen_valid_out), 64'd1);
    check("start_busy", 64'(busy_out), 64'd1);
    check("start_cam", 64'(gen_cam_forward_out), 64'(cam));
    check("start_hv", 64'({gen_hcount_out, gen_vcount_out}), 64'd0);
  endtask

  task automatic wait_frame(string name);
    int d0;
    bit ok;
    d0 = dones;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dones != d0) begin
        ok = 1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    check({name, "_all_consumed"}, 64'(sb.size()), 64'd0);
    check({name, "_accepts"}, 64'(accepts), 64'(W * H));
    check({name, "_busy_after"}, 64'(busy_out), 64'd0);
    check({name, "_one_done"}, 64'(dones - d0), 64'd1);
  endtask

  initial begin
    logic [VW-1:0] cam_a;
    logic [VW-1:0] cam_b;
    int            p0;
    bit            seen;
    rst_n          = 1'b0;
    start_in       = 1'b0;
    cam_forward_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // basic frame
    lat = 3;
    start_frame(48'h1234_5678_9abc);
    wait_frame("basic");

    // downstream backpressure: FIFO fills and requests stop
    rdy_mode = 1;
    start_frame(48'h0f0f_a5a5_3c3c);
    repeat (80) @(negedge clk);
    check("bp_accepts", 64'(accepts), 64'(DEPTH));
    check("bp_gen_valid", 64'(gen_valid_out), 64'd0);
    check("bp_ray_valid", 64'(ray_valid_out), 64'd1);
    check("bp_busy", 64'(busy_out), 64'd1);
    rdy_mode = 0;
    wait_frame("backpressure");

    // stale result valid held between pixels
    stale = 1;
    lat   = 2;
    start_frame(48'hdead_beef_0001);
    wait_frame("stale");
    stale = 0;
    lat   = 3;

    // generator not ready for 10 cycles on the first pixel
    gen_hold = 1;
    start_frame(48'h5555_aaaa_7777);
    repeat (10) begin
      @(negedge clk);
      check("hold_gen_valid", 64'(gen_valid_out), 64'd1);
      check("hold_hv", 64'({gen_hcount_out, gen_vcount_out}), 64'd0);
    end
    check("hold_no_accept", 64'(accepts), 64'd0);
    gen_hold = 0;
    wait_frame("gen_hold");

    // start pulse during WAIT with a new camera vector is ignored
    cam_a = 48'h0102_0304_0506;
    cam_b = 48'hf0e0_d0c0_b0a0;
    start_frame(cam_a);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pend) begin
        seen = 1;
        break;
      end
    end
    check("wait_seen", 64'(seen), 64'd1);
    start_in       = 1'b1;
    cam_forward_in = cam_b;
    @(negedge clk);
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    check("ignored_start_cam", 64'(gen_cam_forward_out), 64'(cam_a));
    wait_frame("busy_start");
    check("cam_after_frame", 64'(gen_cam_forward_out), 64'(cam_a));

    // reset in the middle of a frame, then a fresh frame
    p0 = pops;
    start_frame(48'h7e57_0000_1111);
    for (int i = 0; i < 500 && pops < p0 + 3; i++) @(negedge clk);
    check("mid_pixels_seen", 64'(pops - p0 >= 3), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(48'h2222_3333_4444);
    wait_frame("after_reset");

    // randomized frames
    gen_rand = 1;
    rdy_mode = 2;
    for (int f = 0; f < 5; f++) begin
      lat   = $urandom_range(1, 4);
      stale = ($urandom_range(0, 1) == 1);
      start_frame(VW'({$urandom, $urandom}));
      wait_frame("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Frame-level initiator for the folded ray generator: on a start pulse it scans every pixel in raster order, issues one (hcount, vcount, cam_forward) request at a time over the generator's valid/ready request side, and captures each returned ray direction. Results are tagged with their pixel coordinates and buffered in a small FIFO that feeds the downstream marcher over a valid/ready stream. It sits between the frame controller and the ray marcher and signals frame completion once the last tagged ray has been consumed.

## Interface
- DISPLAY_WIDTH, default `DISPLAY_WIDTH, pixels per line
- DISPLAY_HEIGHT, default `DISPLAY_HEIGHT, lines per frame
- H_BITS, default `H_BITS, hcount width
- V_BITS, default `V_BITS, vcount width
- FIFO_DEPTH, default 4, output FIFO entries (power of two, ≥2)
- clk_in  input  1  single clock
- rst_n_in  input  1  reset; synchronous, active-low
- start_in  input  1  one-cycle frame start; honoured only in IDLE
- cam_forward_in  input  vec3  camera forward, sampled on accepted start_in
- gen_valid_out  output  1  request valid to generator
- gen_ready_in  input  1  generator ready
- gen_hcount_out  output  H_BITS  request hcount
- gen_vcount_out  output  V_BITS  request vcount
- gen_cam_forward_out  output  vec3  latched cam_forward, constant for the frame
- gen_valid_in  input  1  generator result valid (level; may remain high after completion)
- gen_ray_in  input  vec3  generator ray direction
- ray_valid_out  output  1  FIFO not empty
- ray_ready_in  input  1  downstream accepts head entry
- ray_hcount_out  output  H_BITS  head entry hcount
- ray_vcount_out  output  V_BITS  head entry vcount
- ray_direction_out  output  vec3  head entry ray
- busy_out  output  1  high whenever state ≠ IDLE
- frame_done_out  output  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE: start_in → latch cam_forward_in, h=0, v=0, go ISSUE.
- ISSUE: gen_valid_out=1 iff fifo count < FIFO_DEPTH. Accept = gen_valid_out & gen_ready_in at a clock edge → go WAIT. gen_valid_out deasserts the cycle after accept (single request per handshake; never two accepts per pixel).
- WAIT: gen_valid_out=0. On gen_valid_in=1 → push {h, v, gen_ray_in}; if (h,v) = (W-1,H-1) go DRAIN, else advance raster (h+1; at W-1 wrap h=0, v+1) and go ISSUE.
- gen_valid_in outside WAIT is ignored (covers stale level from previous completion).
- DRAIN: when FIFO empty → pulse frame_done_out, go IDLE.
- FIFO: show-ahead; ray_* outputs reflect head; pop on ray_valid_out & ray_ready_in. Push and pop in same cycle: count unchanged, both take effect. Overflow impossible: issue gated on count < FIFO_DEPTH, only one request outstanding.
- gen_hcount_out/gen_vcount_out = current h, v; stable through ISSUE and WAIT.
- start_in while busy: ignored; cam_forward unchanged.

## Timing
- Reset (rst_n_in=0 at edge): state IDLE, FIFO empty, gen_valid_out=0, ray_valid_out=0, busy_out=0, frame_done_out=0, h=v=0, gen_hcount_out=gen_vcount_out=0, cam_forward register and ray data outputs = 0.
- Reset mid-frame: same as above next edge; any generator result arriving after reset ignored (state not WAIT). Generator must be reset concurrently (top level inverts rst_n_in).
- start_in at edge t → gen_valid_out high from t+1 (FIFO empty).
- Result captured at edge where WAIT & gen_valid_in → ray_valid_out high next cycle if FIFO was empty; back in ISSUE that same next cycle.
- Dispatcher overhead per pixel: 1 cycle ISSUE (when ready) + generator latency + 1 capture edge.
- frame_done_out: asserted exactly one cycle, in cycle after DRAIN sees empty FIFO; busy_out falls with it.

## Test plan
- Basic frame: W=4, H=2, mock generator latency 3, ray=f(h,v), ray_ready_in=1 → 8 outputs in order (0,0),(1,0)…(3,1), correct rays, one frame_done_out pulse, busy_out low after.
- Backpressure: ray_ready_in=0 throughout, FIFO_DEPTH=4 → exactly 4 requests accepted, gen_valid_out stays 0 while count=4; raise ready → remaining 4 issued, order intact.
- Stale valid: mock holds gen_valid_in high after completion until next accept → no duplicate pushes; 8 entries total.
- gen_ready_in low 10 cycles in ISSUE → gen_valid_out held high, coordinates stable, single accept when ready rises.
- Reset mid-frame after 3 pixels → all outputs reset values next cycle; subsequent start_in yields a fresh frame beginning at (0,0).
- start_in pulsed during WAIT with different cam_forward_in → ignored; gen_cam_forward_out unchanged until frame end.
